// File: rtl/peripheral_mpi_pkg.sv
// Shared definitions for the MPI peripheral NoC egress path.
// Flit layout and pointer-width helper.
package peripheral_mpi_pkg;

    localparam int NOC_FLIT_WIDTH = 32;

    typedef struct packed {
        logic                      last;
        logic [NOC_FLIT_WIDTH-1:0] data;
    } noc_flit_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/peripheral_mpi_noc_buffer_mem.sv
// Flit storage for the NoC egress buffer.
// One synchronous write port, one asynchronous read port.
module peripheral_mpi_noc_buffer_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_mpi_noc_buffer.sv
// Store-and-forward NoC flit buffer on the MPI peripheral egress side.
// Packet mode holds flits back until a whole packet (or a full buffer) is present.
module peripheral_mpi_noc_buffer
    import peripheral_mpi_pkg::*;
#(
    parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
    parameter int DEPTH      = 16,
    parameter int FULLPACKET = 1,
    localparam int PTR_W     = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PTR_W-1:0]      flit_count,
    output logic [PTR_W-1:0]      pkt_count
);

    localparam int AW = PTR_W - 1;

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    pkt_q;
    logic [FLIT_WIDTH:0] rd_data;
    logic                empty;
    logic                full;
    logic                wr_en;
    logic                rd_en;
    logic                pkt_in;
    logic                pkt_out;

    peripheral_mpi_noc_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_WIDTH + 1)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({in_last, in_flit}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready = !full;
    assign out_last = rd_data[FLIT_WIDTH];
    assign out_flit = rd_data[FLIT_WIDTH-1:0];

    // Full buffer releases an oversize packet cut-through to avoid deadlock.
    always_comb begin
        out_valid = !empty;
        if (FULLPACKET != 0) begin
            out_valid = !empty && ((pkt_q != '0) || full);
        end
    end

    assign wr_en   = in_valid && in_ready;
    assign rd_en   = out_valid && out_ready;
    assign pkt_in  = wr_en && in_last;
    assign pkt_out = rd_en && out_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            pkt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (pkt_in && !pkt_out) begin
                pkt_q <= pkt_q + PTR_W'(1);
            end else if (pkt_out && !pkt_in) begin
                pkt_q <= pkt_q - PTR_W'(1);
            end
        end
    end

    assign flit_count = wr_ptr - rd_ptr;
    assign pkt_count  = pkt_q;

endmodule

// File: doc/peripheral_mpi_noc_buffer.md
Name: peripheral_mpi_noc_buffer

Overview:
Store-and-forward NoC packet buffer on the egress side of the MPI peripheral.
- Input: noc_out_flit/last/valid/ready from peripheral_mpi_tl.
- Output: the same flit stream, forwarded to the NoC router (or looped back to noc_in_* in the bench).
- In packet mode, the downstream side never sees a partial packet, so router links are not held by a slow AHB writer.
- Status outputs expose buffered flit and packet counts.

Parameters:
FLIT_WIDTH, 32, flit data width; matches NOC_FLIT_WIDTH.
DEPTH, 16, flit storage entries; power of two, >= 2; matches SIZE.
FULLPACKET, 1, 1 = store-and-forward; 0 = cut-through FIFO.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_flit  in  FLIT_WIDTH  flit from MPI peripheral
in_last  in  1  marks final flit of packet
in_valid  in  1  input flit valid
in_ready  out  1  buffer accepts flit
out_flit  out  FLIT_WIDTH  flit toward NoC
out_last  out  1  final flit of packet
out_valid  out  1  output flit valid
out_ready  in  1  NoC accepts flit
flit_count  out  $clog2(DEPTH)+1  flits stored
pkt_count  out  $clog2(DEPTH)+1  complete packets stored (last flits stored)

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, flit_count=0, pkt_count=0, in_ready=1 after deassertion, out_valid=0. Memory contents are don't-care. out_flit/out_last are don't-care while out_valid=0.
- Reset mid-packet: all buffered flits are dropped. No partial packet is emitted afterwards.
- Pointers are $clog2(DEPTH)+1 bits wide (extra wrap bit).
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Wrap-around is natural modulo-2*DEPTH arithmetic.
- Write: in_valid && in_ready stores {in_last, in_flit} at wr_ptr and increments wr_ptr. in_ready = !full, combinational from registered state.
  - When full, no write occurs in the same cycle even if a read happens. in_ready does not depend on out_ready.
- Read: first-word-fall-through. out_flit/out_last = mem[rd_ptr]. out_valid && out_ready increments rd_ptr.
- out_valid:
  - FULLPACKET=0: !empty.
  - FULLPACKET=1: !empty && (pkt_count != 0 || full).
  - The "|| full" term is the oversize-packet fallback. A packet longer than DEPTH is emitted cut-through once the buffer fills, so the block never deadlocks.
- Latency: a flit written in cycle t is visible on out_* at cycle t+1 at the earliest. In packet mode, out_valid rises the cycle after the last flit is written.
- flit_count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count: +1 on a write with in_last=1, -1 on a read with out_last=1, unchanged if both occur in one cycle. It never underflows, since an emitted last flit was counted on write.
  - In the oversize fallback, pkt_count stays 0 until the last flit is written; the trailing flits then drain normally.
- Valid/ready protocol: once out_valid=1, out_flit/out_last stay stable until accepted. This holds because only reads change the head entry, and out_valid cannot drop without a read, since pkt_count/full only decrease via reads.
  - Exception: in the oversize fallback, out_valid may drop when full deasserts after a read. This is a permitted gap between flits, never a retraction of an unaccepted flit.
- Empty with simultaneous write: no bypass. The flit appears next cycle.
- Single-flit packet (in_last=1 on first flit): pkt_count becomes 1 next cycle; out_valid=1.
- Interface accepts back-to-back packets; there are no bubbles between packets on either side.

Decomposition:
- Package peripheral_mpi_pkg holds:
  - NOC_FLIT_WIDTH default constant;
  - typedef noc_flit_t (struct: logic last, logic [FLIT_WIDTH-1:0] data);
  - helper constant PTR_W derivation function.
- One sub-module: peripheral_mpi_noc_buffer_mem, a DEPTH x (FLIT_WIDTH+1) storage array with one synchronous write port and one asynchronous read port, no reset.
- Pointer/count/handshake control stays in the top module.

Test Plan:
- Reset then idle:
  - After rst release: in_ready=1, out_valid=0, flit_count=0, pkt_count=0.
  - Toggling out_ready for 10 cycles produces no output.
- Store-and-forward, 4-flit packet (0xA0..0xA3, last on 0xA3) with out_ready=1:
  - out_valid stays 0 during the first 3 writes and rises the cycle after 0xA3 is written.
  - 0xA0..0xA3 emerge on consecutive cycles, out_last=1 on 0xA3.
  - pkt_count goes 0->1->0.
- Full and backpressure, DEPTH=16, out_ready=0, sixteen 1-flit packets:
  - After 16 writes: in_ready=0, flit_count=16, pkt_count=16.
  - Holding in_valid for a 17th flit is ignored until one read occurs, then it is accepted the next cycle.
- Oversize packet, 20 flits (last on flit 20), out_ready=1:
  - out_valid rises when flit_count=16.
  - All 20 flits are delivered in order with out_last only on flit 20, and no deadlock occurs.
- Simultaneous events, steady stream of 2-flit packets with in_valid=out_ready=1:
  - flit_count stabilises.
  - When a last flit is written and a last flit is read in the same cycle, pkt_count is unchanged.
  - Wrap-around past index 15 preserves data order over 100 packets (scoreboard).
- Reset mid-packet:
  - Write 3 flits of a 5-flit packet, then assert rst for 1 cycle.
  - Result: flit_count=0, out_valid=0.
  - A following 2-flit packet (0xB0, 0xB1) is delivered alone and intact.
